dcache_control: RTL and testbench
=================================

// Module: dcache_control
// PURPOSE
//  Sequencing FSM for the 2-way set-associative write-back data cache datapath.
//  - Sits between the CPU bus adaptor (mem_read/mem_write/mem_resp) and the cacheline adaptor (pmem_*).
//  - Decides hit service, dirty-victim writeback and line fill.
//  - Drives the datapath strobes load_data, valid_in and load_waddr.
//  - Keeps saturating hit/miss/writeback performance counters.
// PARAMETERS
//  CNT_W  32  width of each performance counter
// PORTS
//  clk         in   1      clock; all state updates on rising edge
//  rst         in   1      reset, asynchronous, active-low (0 = reset)
//  mem_read    in   1      CPU read request, held until mem_resp
//  mem_write   in   1      CPU write request, held until mem_resp
//  mem_resp    out  1      request complete this cycle
//  hit_any     in   1      datapath: tag match in either valid way
//  dirty       in   1      datapath: LRU way of indexed set is dirty
//  load_data   out  1      datapath: write pmem_rdata into LRU way (full line)
//  valid_in    out  1      datapath: valid bit value for the loaded way
//  load_waddr  out  1      datapath: pmem_address = victim {tag,index}; else CPU line address
//  pmem_read   out  1      cacheline adaptor read request
//  pmem_write  out  1      cacheline adaptor write request (data = LRU way)
//  pmem_resp   in   1      cacheline adaptor done, 1-cycle pulse
//  perf_clr    in   1      synchronous clear of all counters
//  hit_cnt     out  CNT_W  requests served without a miss
//  miss_cnt    out  CNT_W  requests that missed
//  wb_cnt      out  CNT_W  dirty writebacks issued
// BEHAVIOUR
//  - States: CHECK (idle/compare), WRITEBACK, FILL. Reset state CHECK.
//  - Outputs are decoded from state + inputs. All outputs are 0 when idle and when rst=0.
//  - Counters reset to 0.
//  - CHECK:
//    - req = mem_read|mem_write. With no req, stay in CHECK; all outputs 0.
//    - req & hit_any: mem_resp=1 in the same cycle (0 extra latency), stay in CHECK.
//    - On a write hit the datapath itself merges bytes and sets dirty at that edge.
//    - req & !hit_any & dirty: go to WRITEBACK.
//    - req & !hit_any & !dirty: go to FILL.
//  - WRITEBACK:
//    - pmem_write=1, load_waddr=1 held every cycle until pmem_resp.
//    - On pmem_resp go to FILL. pmem_write drops the cycle after the resp edge.
//  - FILL:
//    - pmem_read=1, load_waddr=0, valid_in=1 held until pmem_resp.
//    - load_data=1 only in the pmem_resp cycle. Go to CHECK.
//    - The next CHECK cycle sees hit_any=1 and completes the request.
//  - Miss latency is writeback time + fill time + 1 CHECK cycle.
//  - mem_resp is never asserted outside CHECK.
//  - pmem_read and pmem_write are never both 1 in the same cycle.
//  - Request withdrawn mid-miss (CPU violation):
//    - The in-flight pmem transaction still completes.
//    - FSM returns to CHECK and no mem_resp is issued.
//  - mem_read & mem_write both set: treated as a write.
//  - pmem_resp while in CHECK: ignored.
//  - Counters:
//    - hit_cnt +1 on a CHECK hit cycle whose request did not come from a miss.
//    - miss_cnt +1 on the CHECK->WRITEBACK or CHECK->FILL transition.
//    - wb_cnt +1 on the CHECK->WRITEBACK transition.
//    - A miss's completing hit is not counted as a hit.
//    - Saturate at 2^CNT_W-1, no wrap.
//    - perf_clr wins over a same-cycle increment.
//  - rst=0 at any time:
//    - State goes to CHECK immediately; pmem_read/pmem_write/load_data drop asynchronously.
//    - Counters clear.
//    - A cacheline adaptor mid-burst must also be reset by the same rst.
// TESTING
//  - Read hit: hit_any=1, mem_read=1 -> mem_resp=1 same cycle, no pmem_*; hit_cnt 0->1.
//  - Clean read miss, fill resp after 5 cycles:
//    - hit_any=0, dirty=0 -> pmem_read high 5 cycles, load_data=1 on resp cycle.
//    - Then mem_resp 1 cycle later; miss_cnt=1, wb_cnt=0, hit_cnt=0.
//  - Dirty write miss, wb resp at cycle 4 and fill resp at cycle 4:
//    - pmem_write+load_waddr for 4 cycles, then pmem_read 4 cycles, then mem_resp.
//    - wb_cnt=1, miss_cnt=1; pmem_read and pmem_write never overlap.
//  - Saturation/clear: CNT_W=4, force 17 hits -> hit_cnt=15.
//    - perf_clr together with a hit -> hit_cnt=0.
//  - Abort and reset:
//    - Drop mem_read during FILL -> FILL still completes, no mem_resp, back to CHECK.
//    - rst=0 mid-WRITEBACK -> pmem_write=0 before the next edge; state CHECK; counters 0.
//  - Idle: no request for 20 cycles with random pmem_resp pulses -> all outputs stay 0.

Source files
------------

// File: rtl/dcache_control.sv
// dcache_control: sequencing FSM for a 2-way set-associative write-back data
// cache. Chooses between hit service, dirty-victim writeback and line fill,
// drives the datapath strobes, and keeps saturating performance counters.
module dcache_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             hit_any,
  input  logic             dirty,
  output logic             load_data,
  output logic             valid_in,
  output logic             load_waddr,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  // High during the single CHECK cycle that follows a miss; that cycle's hit
  // only completes the missed request and must not be counted as a hit.
  logic after_miss;

  logic req;
  logic count_hit;
  logic count_miss;
  logic count_wb;

  // A simultaneous read and write is treated as a write; the sequencing is
  // identical for both, so only "some request is pending" matters here.
  assign req = mem_read | mem_write;

  assign count_hit  = (state == CHECK) && req && hit_any && !after_miss;
  assign count_miss = (state == CHECK) && req && !hit_any;
  assign count_wb   = count_miss && dirty;

  // Saturating increment so counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic             enable);
    if (enable && (value != '1)) begin
      return value + CNT_W'(1);
    end
    return value;
  endfunction

  // Next-state selection: a miss picks writeback first if the victim is dirty.
  always_comb begin
    next_state = state;
    case (state)
      CHECK: begin
        if (req && !hit_any) begin
          next_state = dirty ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        if (pmem_resp) begin
          next_state = FILL;
        end
      end
      FILL: begin
        if (pmem_resp) begin
          next_state = CHECK;
        end
      end
      default: next_state = CHECK;
    endcase
  end

  // Mealy output decode; gated by reset so everything is quiet while held.
  always_comb begin
    mem_resp   = 1'b0;
    load_data  = 1'b0;
    valid_in   = 1'b0;
    load_waddr = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    if (rst) begin
      case (state)
        CHECK: begin
          mem_resp = req && hit_any;
        end
        WRITEBACK: begin
          pmem_write = 1'b1;
          load_waddr = 1'b1;
        end
        FILL: begin
          pmem_read = 1'b1;
          valid_in  = 1'b1;
          load_data = pmem_resp;
        end
        default: ;
      endcase
    end
  end

  // State register plus the one-cycle "just returned from a miss" marker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= CHECK;
      after_miss <= 1'b0;
    end else begin
      state      <= next_state;
      after_miss <= (state != CHECK);
    end
  end

  // Performance counters; a clear request overrides any same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else if (perf_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      hit_cnt  <= sat_inc(hit_cnt, count_hit);
      miss_cnt <= sat_inc(miss_cnt, count_miss);
      wb_cnt   <= sat_inc(wb_cnt, count_wb);
    end
  end

endmodule

// File: tb/tb_dcache_control.sv
// tb_dcache_control: randomized scoreboard bench for dcache_control.
// The bench plays CPU, datapath and cacheline adaptor; expected latencies,
// pmem activity and counter values are derived per request and queued.
module tb_dcache_control;

  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_read;
  logic             mem_write;
  logic             mem_resp;
  logic             hit_any;
  logic             dirty;
  logic             load_data;
  logic             valid_in;
  logic             load_waddr;
  logic             pmem_read;
  logic             pmem_write;
  logic             pmem_resp;
  logic             perf_clr;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic [CNT_W-1:0] wb_cnt;

  typedef struct {
    int lat;
    int rd;
    int wr;
    int ld;
    int hits;
    int misses;
    int wbs;
  } exp_t;

  exp_t expQ[$];

  int checks = 0;
  int failures = 0;
  int wbLat = 1;
  int fillLat = 1;
  bit idleMode = 1'b0;
  int mHit = 0;
  int mMiss = 0;
  int mWb = 0;
  logic hitReq;
  int fillCount = 0;
  int fillBase = 0;

  // The line counts as present once a fill has landed since the request began.
  assign hit_any = hitReq | (fillCount != fillBase);

  dcache_control #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_resp   (mem_resp),
    .hit_any    (hit_any),
    .dirty      (dirty),
    .load_data  (load_data),
    .valid_in   (valid_in),
    .load_waddr (load_waddr),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_resp  (pmem_resp),
    .perf_clr   (perf_clr),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
    .wb_cnt     (wb_cnt)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v < MAXC) ? v + 1 : v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic finishNow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Cacheline adaptor: answers the N-th cycle of a request with a resp pulse.
  initial begin : responder
    int cnt;
    cnt = 0;
    pmem_resp = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (idleMode) begin
        pmem_resp = 1'($urandom_range(0, 1));
        cnt = 0;
      end else if (pmem_read || pmem_write) begin
        cnt++;
        pmem_resp = (cnt == (pmem_write ? wbLat : fillLat));
        if (pmem_resp) cnt = 0;
      end else begin
        cnt = 0;
        pmem_resp = 1'b0;
      end
    end
  end

  // Datapath: a completed fill makes the requested line hit from the next cycle.
  initial begin : datapath
    forever begin
      @(negedge clk);
      if (rst && load_data) begin
        @(posedge clk);
        #1;
        fillCount++;
      end
    end
  end

  // Monitor: tracks each queued request and checks it when mem_resp appears.
  initial begin : monitor
    int ncyc;
    int start;
    int rdC;
    int wrC;
    int ldC;
    bit tracking;
    bit overlap;
    bit waddrBad;
    bit validBad;
    bit respBusy;
    bit cntPending;
    exp_t cur;
    ncyc = 0; start = 0; rdC = 0; wrC = 0; ldC = 0;
    tracking = 0; overlap = 0; waddrBad = 0; validBad = 0; respBusy = 0; cntPending = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (cntPending && rst) begin
        checkOutput("hit_cnt", int'(hit_cnt), cur.hits);
        checkOutput("miss_cnt", int'(miss_cnt), cur.misses);
        checkOutput("wb_cnt", int'(wb_cnt), cur.wbs);
        cntPending = 0;
      end
      if (!tracking && (expQ.size() > 0) && (mem_read || mem_write)) begin
        tracking = 1; start = ncyc;
        rdC = 0; wrC = 0; ldC = 0;
        overlap = 0; waddrBad = 0; validBad = 0; respBusy = 0;
      end
      if (tracking) begin
        rdC += int'(pmem_read);
        wrC += int'(pmem_write);
        ldC += int'(load_data);
        if (pmem_read && pmem_write) overlap = 1;
        if (load_waddr != pmem_write) waddrBad = 1;
        if (valid_in != pmem_read) validBad = 1;
        if (mem_resp && (pmem_read || pmem_write)) respBusy = 1;
      end
      if (mem_resp) begin
        if (!tracking) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_mem_resp actual=1 required=0");
        end else begin
          cur = expQ.pop_front();
          checkOutput("resp_latency", ncyc - start, cur.lat);
          checkOutput("pmem_read_cycles", rdC, cur.rd);
          checkOutput("pmem_write_cycles", wrC, cur.wr);
          checkOutput("load_data_cycles", ldC, cur.ld);
          checkOutput("rw_overlap", int'(overlap), 0);
          checkOutput("waddr_vs_write", int'(waddrBad), 0);
          checkOutput("valid_vs_read", int'(validBad), 0);
          checkOutput("resp_during_pmem", int'(respBusy), 0);
          tracking = 0;
          cntPending = 1;
        end
      end
    end
  end

  // Issue one request (kind 0 hit, 1 clean miss, 2 dirty miss) and wait for it.
  task automatic applyStimulus(input int kind, input int wb, input int fill,
                               input bit rd, input bit wr, input bit clr);
    exp_t e;
    int n;
    wbLat = wb;
    fillLat = fill;
    mem_read = rd;
    mem_write = wr;
    perf_clr = clr;
    if (kind == 2) dirty = 1'b1;
    else if (kind == 1) dirty = 1'b0;
    else dirty = 1'($urandom_range(0, 1));
    fillBase = fillCount;
    hitReq = (kind == 0);
    if (kind == 0) begin
      mHit = sat(mHit);
    end else begin
      mMiss = sat(mMiss);
      if (kind == 2) mWb = sat(mWb);
    end
    if (clr) begin
      mHit = 0; mMiss = 0; mWb = 0;
    end
    e.lat = (kind == 0) ? 0 : ((kind == 2) ? wb : 0) + fill + 1;
    e.rd = (kind == 0) ? 0 : fill;
    e.wr = (kind == 2) ? wb : 0;
    e.ld = (kind == 0) ? 0 : 1;
    e.hits = mHit;
    e.misses = mMiss;
    e.wbs = mWb;
    expQ.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_resp && n < 100);
    if (!mem_resp) begin
      checks++;
      failures++;
      $display("[TB] FAIL resp_timeout actual=0 required=1");
      finishNow();
    end
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    perf_clr = 1'b0;
    hitReq = 1'b0;
    dirty = 1'b0;
    fillBase = fillCount;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : watchdog
    #2000000;
    checks++;
    failures++;
    $display("[TB] FAIL global_timeout actual=expired required=done");
    finishNow();
  end

  initial begin : stimulus
    int kind;
    int rw;
    int n;
    bit seen;
    bit respSeen;
    rst = 1'b0;
    mem_read = 1'b1;
    mem_write = 1'b0;
    hitReq = 1'b1;
    dirty = 1'b0;
    perf_clr = 1'b0;

    // Reset state: request presented during reset must not be answered.
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs",
                int'({mem_resp, load_data, valid_in, load_waddr, pmem_read, pmem_write}), 0);
    checkOutput("reset_hit_cnt", int'(hit_cnt), 0);
    checkOutput("reset_miss_cnt", int'(miss_cnt), 0);
    checkOutput("reset_wb_cnt", int'(wb_cnt), 0);
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    hitReq = 1'b0;
    rst = 1'b1;
    idleCycles(1);

    // Saturation: 17 back-to-back hits leave hit_cnt at 15.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(0, 1, 1, 1'b1, 1'b0, 1'b0);
    end
    // Clear coinciding with a hit wins.
    applyStimulus(0, 1, 1, 1'b0, 1'b1, 1'b1);
    idleCycles(1);

    // Clean read miss, fill answers on its 5th cycle.
    applyStimulus(1, 1, 5, 1'b1, 1'b0, 1'b0);
    idleCycles(1);
    // Dirty write miss, writeback and fill each answer on their 4th cycle.
    applyStimulus(2, 4, 4, 1'b0, 1'b1, 1'b0);
    // Hit straight after a miss completion is a fresh, counted hit.
    applyStimulus(0, 1, 1, 1'b1, 1'b1, 1'b0);

    // Randomized mix of hits and misses with varying adaptor latency.
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 2));
      rw = int'($urandom_range(1, 3));
      applyStimulus(kind, int'($urandom_range(1, 5)), int'($urandom_range(1, 6)),
                    rw[0], rw[1], 1'b0);
      if ($urandom_range(0, 2) == 0) idleCycles(int'($urandom_range(1, 2)));
    end

    // Request withdrawn during FILL: the fill completes, no response follows.
    wbLat = 1;
    fillLat = 6;
    mem_read = 1'b1;
    dirty = 1'b0;
    hitReq = 1'b0;
    fillBase = fillCount;
    mMiss = sat(mMiss);
    idleCycles(3);
    mem_read = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (load_data) seen = 1'b1;
    end
    checkOutput("abort_fill_done", int'(seen), 1);
    respSeen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (mem_resp) respSeen = 1'b1;
    end
    checkOutput("abort_no_resp", int'(respSeen), 0);
    @(posedge clk);
    #1;
    fillBase = fillCount;
    applyStimulus(0, 1, 1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1, 1, 2, 1'b1, 1'b0, 1'b0);

    // Reset asserted in the middle of a writeback.
    wbLat = 10;
    fillLat = 2;
    mem_write = 1'b1;
    dirty = 1'b1;
    hitReq = 1'b0;
    fillBase = fillCount;
    idleCycles(3);
    #1;
    checkOutput("pre_rst_pmem_write", int'(pmem_write), 1);
    rst = 1'b0;
    #1;
    checkOutput("rst_pmem_drop", int'({pmem_read, pmem_write, load_data, load_waddr}), 0);
    @(negedge clk);
    checkOutput("rst_hit_cnt", int'(hit_cnt), 0);
    checkOutput("rst_miss_cnt", int'(miss_cnt), 0);
    checkOutput("rst_wb_cnt", int'(wb_cnt), 0);
    checkOutput("rst_mem_resp", int'(mem_resp), 0);
    mem_write = 1'b0;
    dirty = 1'b0;
    mHit = 0;
    mMiss = 0;
    mWb = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idleCycles(1);
    applyStimulus(0, 1, 1, 1'b1, 1'b0, 1'b0);
    applyStimulus(2, 2, 3, 1'b1, 1'b0, 1'b0);

    // Idle: random datapath inputs and stray adaptor pulses, no request.
    idleMode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      hitReq = 1'($urandom_range(0, 1));
      dirty = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("idle_outputs",
                  int'({mem_resp, load_data, valid_in, load_waddr, pmem_read, pmem_write}), 0);
      @(posedge clk);
      #1;
    end
    idleMode = 1'b0;
    hitReq = 1'b0;
    dirty = 1'b0;
    idleCycles(2);
    applyStimulus(0, 1, 1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1, 1, 3, 1'b0, 1'b1, 1'b0);
    idleCycles(2);

    checkOutput("queue_drained", expQ.size(), 0);
    finishNow();
  end

endmodule
